uart_mmio_fifo: RTL and testbench

//  Buffered memory-mapped UART port between the CPU MEM stage and the UART byte transceiver.
//  - RX FIFO: captures bytes from the receiver.
//  - TX FIFO: queues bytes for the transmitter.
//  The CPU reaches both through four word registers, so software no longer busy-waits per byte.

---
 rtl/uart_mmio_fifo.sv | 130 +++++++++++++
 tb/tb_uart_mmio_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART port: RX and TX byte FIFOs behind STATUS/RXDATA/TXDATA/STATS word registers.
// Optional build macro UART_FIFO_STATS_EN adds the occupancy register at 0xC and a sticky rx_stall flag.
module uart_mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]  rxMem [DEPTH];
    logic [AW-1:0] rxWrPtr, rxRdPtr;
    logic [AW:0] rxCount;
    logic [7:0]  txMem [DEPTH];
    logic [AW-1:0] txWrPtr, txRdPtr;
    logic [AW:0] txCount;
    logic        txDrop;
    logic        stallBit;

    logic rxFull, rxNonEmpty, txFull, txNonEmpty;
    logic rxPush, rxPop, txPush, txPop, txWrite, statusRead;
    logic [7:0] rxHead;

    assign rxFull     = (rxCount == FULL_COUNT);
    assign rxNonEmpty = (rxCount != '0);
    assign txFull     = (txCount == FULL_COUNT);
    assign txNonEmpty = (txCount != '0);

    // Valid/ready: a byte moves on an edge where both sides are high; ready depends only on registered counts.
    assign uart_rx_ready = !rxFull;
    assign uart_tx_valid = txNonEmpty;
    assign uart_tx_data  = txNonEmpty ? txMem[txRdPtr] : 8'h00;

    assign statusRead = rd_en && (addr == 4'h0);
    assign txWrite    = wr_en && (addr == 4'h8);
    assign rxPush     = uart_rx_valid && !rxFull;
    assign rxPop      = rd_en && (addr == 4'h4) && rxNonEmpty;
    assign txPush     = txWrite && !txFull;
    assign txPop      = uart_tx_valid && uart_tx_ready;
    assign rxHead     = rxNonEmpty ? rxMem[rxRdPtr] : 8'h00;

    always_ff @(posedge clk) begin
        if (rxPush) rxMem[rxWrPtr] <= uart_rx_data;
        if (txPush) txMem[txWrPtr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            rxCount <= '0;
            txWrPtr <= '0;
            txRdPtr <= '0;
            txCount <= '0;
        end else begin
            if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
            if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
            if (txPush) txWrPtr <= txWrPtr + 1'b1;
            if (txPop)  txRdPtr <= txRdPtr + 1'b1;
            case ({rxPush, rxPop})
                2'b10:   rxCount <= rxCount + 1'b1;
                2'b01:   rxCount <= rxCount - 1'b1;
                default: rxCount <= rxCount;
            endcase
            case ({txPush, txPop})
                2'b10:   txCount <= txCount + 1'b1;
                2'b01:   txCount <= txCount - 1'b1;
                default: txCount <= txCount;
            endcase
        end
    end

    // A drop on the same edge as a STATUS read stays set, so the event is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txDrop <= 1'b0;
        end else if (txWrite && txFull) begin
            txDrop <= 1'b1;
        end else if (statusRead) begin
            txDrop <= 1'b0;
        end
    end

`ifdef UART_FIFO_STATS_EN
    logic rxStall;
    logic [31:0] statsWord;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxStall <= 1'b0;
        end else if (uart_rx_valid && rxFull) begin
            rxStall <= 1'b1;
        end else if (statusRead) begin
            rxStall <= 1'b0;
        end
    end

    assign stallBit  = rxStall;
    assign statsWord = {16'h0000, 8'(txCount), 8'(rxCount)};
`else
    assign stallBit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            case (addr)
                4'h0:    rdata <= {28'h0, stallBit, txDrop, rxNonEmpty, !txFull};
                4'h4:    rdata <= {24'h0, rxHead};
`ifdef UART_FIFO_STATS_EN
                4'hC:    rdata <= statsWord;
`endif
                default: rdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register reads and TX bytes are checked by monitors against expected queues.
module tb_uart_mmio_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        rd_en, wr_en;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;

    int total = 0;
    int bad = 0;
    logic [31:0] expQ[$];
    logic [7:0]  txExpQ[$];
    logic        rdFlag;
    logic [31:0] stallMask;

    uart_mmio_fifo #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Read response monitor: rdata is valid the cycle after the edge that saw rd_en.
    always @(posedge clk or negedge rst) begin
        if (!rst) rdFlag <= 1'b0;
        else      rdFlag <= rd_en;
    end

    always @(negedge clk) begin
        if (rst && rdFlag) begin
            if (expQ.size() == 0) check("rdata_unexpected", rdata, 32'hdead_beef);
            else check("rdata", rdata, expQ.pop_front());
        end
    end

    // TX monitor: a byte leaves on each edge where valid and ready are both high.
    always @(negedge clk) begin
        if (rst && uart_tx_valid && uart_tx_ready) begin
            if (txExpQ.size() == 0) check("tx_unexpected", {24'h0, uart_tx_data}, 32'h0000_0100);
            else check("tx_data", {24'h0, uart_tx_data}, {24'h0, txExpQ.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuRead(input logic [3:0] a, input logic [31:0] exp);
        tick();
        rd_en = 1'b1;
        addr = a;
        expQ.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic cpuWrite(input logic [7:0] d);
        tick();
        wr_en = 1'b1;
        addr = 4'h8;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rxSend(input logic [7:0] d);
        tick();
        uart_rx_valid = 1'b1;
        uart_rx_data = d;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
`ifdef UART_FIFO_STATS_EN
        stallMask = 32'h8;
`else
        stallMask = 32'h0;
`endif
        rst = 1'b0;
        addr = '0; rd_en = 0; wr_en = 0; wdata = '0;
        uart_rx_data = '0; uart_rx_valid = 0; uart_tx_ready = 0;

        // Reset with random activity on every input.
        for (int i = 0; i < 5; i++) begin
            tick();
            addr = 4'($urandom_range(0, 15));
            rd_en = 1'($urandom_range(0, 1));
            wr_en = 1'($urandom_range(0, 1));
            wdata = 8'($urandom_range(0, 255));
            uart_rx_data = 8'($urandom_range(0, 255));
            uart_rx_valid = 1'($urandom_range(0, 1));
            uart_tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_rdata", rdata, 32'h0);
            check("reset_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
            check("reset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        end
        tick();
        addr = '0; rd_en = 0; wr_en = 0; uart_rx_valid = 0; uart_tx_ready = 0;
        rst = 1'b1;
        cpuRead(4'h0, 32'h1);

        // RX path and undefined/unused offsets.
        rxSend(8'h41); rxSend(8'h42); rxSend(8'h43);
        cpuRead(4'h0, 32'h3);
`ifdef UART_FIFO_STATS_EN
        cpuRead(4'hC, 32'h0000_0003);
`else
        cpuRead(4'hC, 32'h0);
`endif
        cpuRead(4'h8, 32'h0);
        cpuRead(4'h4, 32'h41);
        cpuRead(4'h4, 32'h42);
        cpuRead(4'h4, 32'h43);
        cpuRead(4'h4, 32'h0);
        cpuRead(4'h0, 32'h1);

        // RX full: valid held 10 cycles, only 8 bytes accepted.
        for (int i = 0; i < 10; i++) begin
            tick();
            uart_rx_valid = 1'b1;
            uart_rx_data = 8'(8'h50 + i);
            @(negedge clk);
            check("rx_ready_fill", {31'h0, uart_rx_ready}, (i < 8) ? 32'h1 : 32'h0);
        end
        tick();
        uart_rx_valid = 1'b0;
        cpuRead(4'h4, 32'h50);
        @(negedge clk);
        check("rx_ready_after_pop", {31'h0, uart_rx_ready}, 32'h1);
        cpuRead(4'h0, 32'h3 | stallMask);
        for (int i = 1; i < 8; i++) cpuRead(4'h4, 32'(8'h50 + i));
        cpuRead(4'h4, 32'h0);
        cpuRead(4'h0, 32'h1);

        // TX full and drop; one RX byte parked so rx_nonempty shows.
        rxSend(8'h99);
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpuWrite(8'(i));
            if (i < 8) txExpQ.push_back(8'(i));
        end
        cpuRead(4'h0, 32'h6);
        cpuRead(4'h0, 32'h2);
        tick();
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 20 && uart_tx_valid; i++) tick();
        @(negedge clk);
        check("tx_drained_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("tx_left_in_queue", 32'(txExpQ.size()), 32'h0);
        cpuRead(4'h4, 32'h99);
        cpuRead(4'h0, 32'h1);

        // Stream 20 bytes through RX with a pop every cycle after the first push.
        for (int k = 0; k <= 20; k++) begin
            tick();
            uart_rx_valid = (k < 20);
            uart_rx_data = 8'(8'h60 + k);
            rd_en = (k >= 1);
            addr = 4'h4;
            if (k >= 1) expQ.push_back(32'(8'h60 + k - 1));
            @(negedge clk);
            check("stream_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        end
        tick();
        rd_en = 1'b0;
        uart_rx_valid = 1'b0;
        cpuRead(4'h4, 32'h0);
        cpuRead(4'h0, 32'h1);

        // Async reset with RX count 5 and TX count 3.
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) rxSend(8'(8'h70 + i));
        for (int i = 0; i < 3; i++) cpuWrite(8'(8'h80 + i));
        cpuRead(4'h0, 32'h3);
        @(negedge clk);
        check("pre_reset_tx_valid", {31'h0, uart_tx_valid}, 32'h1);
        tick();
        #1;
        rst = 1'b0;
        txExpQ.delete();
        #1;
        check("midreset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("midreset_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        check("midreset_rdata", rdata, 32'h0);
        tick();
        rst = 1'b1;
        cpuRead(4'h0, 32'h1);
        cpuRead(4'h4, 32'h0);

        tick();
        tick();
        check("rd_left_in_queue", 32'(expQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
